// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } dmem_state_t;

  localparam int unsigned DMEM_CNT_W    = 3;
  localparam logic [3:0]  DMEM_NO_WRITE = 4'b0000;

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage data-memory port: request from the pipeline, response from the responder.
interface dmem_responder_if;

  logic        req_valid;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp_valid;
  logic        stall;
  logic        err;

  modport master (
    output req_valid, wen, addr, wdata,
    input  rdata, resp_valid, stall, err
  );

  modport slave (
    input  req_valid, wen, addr, wdata,
    output rdata, resp_valid, stall, err
  );

endinterface

// File: rtl/dmem_bram.sv
// Single-port word array with byte-lane write enables; read-during-write returns the merged word.
module dmem_bram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;
  logic [31:0] merged;

  always_comb begin
    merged = mem_q[addr_i];
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) merged[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

  // Array is deliberately not reset; contents survive rst.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (|we_i) mem_q[addr_i] <= merged;
      rdata_q <= merged;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one request, waits LATENCY cycles, then pulses a response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam logic [DMEM_CNT_W-1:0] LatCnt = DMEM_CNT_W'(LATENCY);
  localparam logic [DMEM_CNT_W-1:0] CntOne = DMEM_CNT_W'(1);

  dmem_state_t           state_q;
  logic [DMEM_CNT_W-1:0] cnt_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wen_q;
  logic                  resp_valid_q;
  logic                  err_q;
  logic                  rdata_vld_q;

  logic        take_req;
  logic        access;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wen;
  logic        in_range;
  logic [31:0] bram_rdata;
  logic        unused_addr;

  assign take_req = (state_q == StIdle) && bus.req_valid;

  // With zero wait states the array is accessed straight from the live request.
  assign access = (take_req && (LATENCY == 0)) || ((state_q == StBusy) && (cnt_q == CntOne));

  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
      acc_wen   = bus.wen;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wen   = wen_q;
    end
  end

  assign in_range    = (acc_addr[31:ADDR_W+2] == '0);
  assign unused_addr = ^acc_addr[1:0];

  dmem_bram #(
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk_i   (clk),
    .en_i    (access && in_range),
    .we_i    (in_range ? acc_wen : DMEM_NO_WRITE),
    .addr_i  (acc_addr[ADDR_W+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (bram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= DMEM_NO_WRITE;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_vld_q  <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (access) begin
        resp_valid_q <= 1'b1;
        rdata_vld_q  <= in_range;
        if (!in_range) err_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            wen_q   <= bus.wen;
            cnt_q   <= LatCnt;
            state_q <= (LATENCY == 0) ? StDone : StBusy;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntOne) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // An out-of-range access returns zero rather than whatever the array port last held.
  assign bus.rdata      = rdata_vld_q ? bram_rdata : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.err        = err_q;
  assign bus.stall      = rst && (take_req || (state_q == StBusy));

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined CPU's memory stage. It accepts one word-wide request at a time from the M-stage: an address, byte-lane write enables and lane-aligned write data. It then holds the pipeline through a configurable number of wait states and returns the read word with a one-cycle response pulse. It is the target end of the CPU's data-memory port and replaces the ideal zero-wait data RAM. It owns the word array and the wait-state sequencing.

## Interface
Clocking is decided: one clock `clk`; reset `rst` is asynchronous and active-low.

Parameters:
- `ADDR_W`, 10: word-address width; array depth is 2^ADDR_W words of 32 bits.
- `LATENCY`, 2: wait states per access, legal range 0..7.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  M-stage holds a load or store this cycle.
- `wen`  in  4  byte-lane write enables; 4'b0000 means read.
- `addr`  in  32  byte address; word index is `addr[ADDR_W+1:2]`.
- `wdata`  in  32  lane-aligned store data.
- `rdata`  out  32  registered response word.
- `resp_valid`  out  1  one-cycle pulse; `rdata` is valid and the store is committed.
- `stall`  out  1  M-stage must hold; high while a request is accepted or in progress.
- `err`  out  1  sticky flag; set when an address is out of range.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - When `req_valid`=1, latch `addr`, `wen` and `wdata`, and load `cnt` with LATENCY.
  - Next state is BUSY if LATENCY>0, otherwise DONE, with the array access performed on that edge.
  - When `req_valid`=0, stay in IDLE.
- **BUSY**
  - `cnt` decrements each cycle.
  - On the edge where `cnt` equals 1, perform the array access and go to DONE.
- **DONE**
  - `resp_valid`=1 and `stall`=0, so the pipeline advances on this edge.
  - `req_valid` is ignored, because it is still the same request.
  - Next state is always IDLE.
- **Access**
  - For each lane i where `wen[i]`=1, write `wdata[8i+7:8i]` into the array word.
  - `rdata` receives the post-merge word. For a read this is the unmodified word.
- **Range check**
  - If `addr[31:ADDR_W+2]` is non-zero, the write is suppressed, `rdata`=0 and `err` is set.
  - The response still completes normally.
- The low address bits `addr[1:0]` are not checked; lane steering and sign-extension stay in the pipeline's memory control logic.
- `stall` = (IDLE and `req_valid`) or BUSY. This is combinational, so the pipeline sees it in the request cycle.

## Timing
- Reset values: state IDLE, `cnt` 0, `rdata` 0, `resp_valid` 0, `stall` 0, `err` 0.
- Array contents are not reset and are retained across `rst`.
- The request is presented in cycle 0.
- `stall` is high for cycles 0..LATENCY.
- `resp_valid` is high, with `rdata` valid, in cycle LATENCY+1.
- LATENCY=0 gives 1 stall cycle, with the response in cycle 1.
- Back-to-back requests: the next request is accepted in the cycle after DONE. This gives a throughput of one access per LATENCY+2 cycles.
- If `req_valid` deasserts in BUSY, the latched request still completes and a response is issued.
- Inputs that change during BUSY are ignored; only the values latched in IDLE are used.
- If reset is asserted mid-access, all registers return to reset values immediately.
  - If the write edge has not yet occurred, the store is not performed.
  - Otherwise the written word stands.
- `err` is cleared only by `rst`.

## Structure
- Shared package `dmem_pkg`:
  - state encoding `dmem_state_t` (IDLE, BUSY, DONE);
  - `DMEM_CNT_W`=3;
  - constant `DMEM_NO_WRITE`=4'b0000.
- One sub-module `dmem_bram`:
  - holds the array of 2^ADDR_W words of 32 bits;
  - one port with per-byte write enable, synchronous read-during-write returning new data;
  - instantiated once by `dmem_responder`.

## Test plan
- **Reset:** with `rst`=0 and `req_valid`=1, all outputs are 0. After `rst` rises, the first access proceeds normally.
- **Full store, then load (LATENCY=2):** store `wen`=4'hF, `addr`=0x10, `wdata`=0xDEADBEEF. `stall` is high for 3 cycles and `resp_valid` pulses in cycle 3. A following read of 0x10 returns `rdata`=0xDEADBEEF.
- **Partial store:** store `wen`=4'b0010, `wdata`=0x0000AA00 to 0x10. A read returns 0xDEADAAEF.
- **LATENCY=0 back-to-back:** two reads are presented on consecutive accept windows. Each gives 1 stall cycle and one response, with responses 2 cycles apart.
- **Out of range (ADDR_W=10):** store to 0x1000 with `wen`=4'hF. `err` goes to 1, `rdata` is 0, and a read of 0x0 still returns the old data.
- **Reset mid-BUSY:** assert `rst` in cycle 1 of a store. No `resp_valid` is seen and the target word is unchanged.
